// File: rtl/mips_bus_arbiter_pkg.sv
// mips_bus_pkg: shared types and bus constants for the CPU memory-bus arbiter.
// Exports: arb_state_t (arbiter FSM states), req_id_t (requester identity),
//          BUS_ADDR_W / BUS_DATA_W / BUS_BE_W default bus geometry.
package mips_bus_pkg;

  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DATA_W = 32;
  localparam int BUS_BE_W   = BUS_DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE,
    BUSY_I,
    BUSY_D,
    RESP_I,
    RESP_D
  } arb_state_t;

  typedef enum logic {
    REQ_I,
    REQ_D
  } req_id_t;

endpackage

// File: rtl/mips_bus_arbiter_if.sv
// mips_bus_arbiter_if: one Avalon-style fixed-latency memory port.
// Signals: address/read/write/writedata/byteenable (initiator -> target),
//          waitrequest/readdata/readdatavalid (target -> initiator).
// Modports: master = initiator side, slave = target side.
interface mips_bus_arbiter_if
  import mips_bus_pkg::*;
#(
  parameter int ADDR_W = BUS_ADDR_W,
  parameter int DATA_W = BUS_DATA_W
) ();

  logic [ADDR_W-1:0]   address;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W/8-1:0] byteenable;
  logic                waitrequest;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;

  modport master (
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata, readdatavalid
  );

endinterface

// File: rtl/mips_bus_arbiter.sv
// mips_bus_arbiter: shares one memory bus between instruction fetch (I) and
// load/store (D), round-robin on ties, grant held until the transaction ends.
// Ports: clk, reset (sync, active low); i_bus/d_bus = requester ports (slave);
//        mem_bus = shared memory bus (master). readdata fans out to both
//        requesters, only the readdatavalid pulse is routed.
module mips_bus_arbiter
  import mips_bus_pkg::*;
#(
  parameter int ADDR_W       = BUS_ADDR_W,
  parameter int DATA_W       = BUS_DATA_W,
  parameter int READ_LATENCY = 1
) (
  input  logic               clk,
  input  logic               reset,
  mips_bus_arbiter_if.slave  i_bus,
  mips_bus_arbiter_if.slave  d_bus,
  mips_bus_arbiter_if.master mem_bus
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LATENCY - 1);

  arb_state_t       state, state_nxt;
  req_id_t          last_grant, last_grant_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic i_req, d_req;
  assign i_req = i_bus.read | i_bus.write;
  assign d_req = d_bus.read | d_bus.write;

  // Fields of whichever requester owns the bus in BUSY_x.
  logic              sel_i;
  logic [ADDR_W-1:0] sel_address;
  logic              sel_read, sel_write;
  logic [DATA_W-1:0] sel_writedata;
  logic [BE_W-1:0]   sel_byteenable;

  assign sel_i          = (state == BUSY_I);
  assign sel_address    = sel_i ? i_bus.address    : d_bus.address;
  assign sel_read       = sel_i ? i_bus.read       : d_bus.read;
  assign sel_write      = sel_i ? i_bus.write      : d_bus.write;
  assign sel_writedata  = sel_i ? i_bus.writedata  : d_bus.writedata;
  assign sel_byteenable = sel_i ? i_bus.byteenable : d_bus.byteenable;

  assign i_bus.readdata = mem_bus.readdata;
  assign d_bus.readdata = mem_bus.readdata;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      last_grant <= REQ_D;
      cnt        <= '0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      cnt        <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt           = state;
    last_grant_nxt      = last_grant;
    cnt_nxt             = cnt;
    mem_bus.address     = '0;
    mem_bus.read        = 1'b0;
    mem_bus.write       = 1'b0;
    mem_bus.writedata   = '0;
    mem_bus.byteenable  = '0;
    i_bus.waitrequest   = 1'b1;
    d_bus.waitrequest   = 1'b1;
    i_bus.readdatavalid = 1'b0;
    d_bus.readdatavalid = 1'b0;

    // While reset is held the outputs stay at their idle values, so a
    // response due in the same cycle is suppressed rather than leaking out.
    if (reset) begin
      unique case (state)
        IDLE: begin
          if (i_req && (!d_req || last_grant == REQ_D)) begin
            state_nxt      = BUSY_I;
            last_grant_nxt = REQ_I;
          end else if (d_req) begin
            state_nxt      = BUSY_D;
            last_grant_nxt = REQ_D;
          end
        end

        BUSY_I, BUSY_D: begin
          mem_bus.address    = sel_address;
          mem_bus.write      = sel_write;
          // read+write together is forwarded as a plain write.
          mem_bus.read       = sel_read & ~sel_write;
          mem_bus.writedata  = sel_writedata;
          mem_bus.byteenable = sel_byteenable;
          if (sel_i) i_bus.waitrequest = mem_bus.waitrequest;
          else       d_bus.waitrequest = mem_bus.waitrequest;

          if (!(sel_read || sel_write)) begin
            // Requester abandoned the request: release without a bus access.
            state_nxt = IDLE;
          end else if (!mem_bus.waitrequest) begin
            if (sel_write) begin
              state_nxt = IDLE;
            end else begin
              state_nxt = sel_i ? RESP_I : RESP_D;
              cnt_nxt   = CNT_LOAD;
            end
          end
        end

        RESP_I, RESP_D: begin
          if (cnt != '0) begin
            cnt_nxt = cnt - 1'b1;
          end else begin
            if (state == RESP_I) i_bus.readdatavalid = 1'b1;
            else                 d_bus.readdatavalid = 1'b1;
            state_nxt = IDLE;
          end
        end

        default: state_nxt = IDLE;
      endcase
    end
  end

  logic illegal_rw;
  assign illegal_rw = (state == BUSY_I || state == BUSY_D) && sel_read && sel_write;

  assert property (@(posedge clk) disable iff (!reset) !illegal_rw);

endmodule
